// File: rtl/dual_port_ssram_pkg.sv
// Shared types and byte-merge helpers for the byte-enabled dual-port SSRAM.
// Helpers work on a fixed maximum word width; callers zero-extend in and truncate out.
package dual_port_ssram_pkg;

    localparam int MAX_BYTES = 64;
    localparam int MAX_BITS  = MAX_BYTES * 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    typedef logic [MAX_BITS-1:0]  word_t;
    typedef logic [MAX_BYTES-1:0] mask_t;

    typedef struct packed {
        word_t data;
        mask_t mask;
    } wr_t;

    function automatic word_t mergeBytes(word_t oldW, word_t newW, mask_t mask);
        word_t r;
        r = oldW;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (mask[i]) r[8*i +: 8] = newW[8*i +: 8];
        end
        return r;
    endfunction

    // Port A owns every byte it enables; port B fills only the bytes A leaves alone.
    function automatic wr_t resolveWrite(word_t dataA, mask_t maskA, word_t dataB, mask_t maskB);
        wr_t r;
        r.data = mergeBytes(dataB, dataA, maskA);
        r.mask = maskA | maskB;
        return r;
    endfunction

endpackage

// File: rtl/ssram_clear_sequencer.sv
// Post-reset clear sequencer: walks every entry once, one write per cycle.
// busy_o stays high until the edge that commits the final entry.
module ssram_clear_sequencer #(
    parameter int nrOfEntries  = 512,
    parameter bit clearOnReset = 1'b1,
    parameter int addrWidth    = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 busy_o,
    output logic                 clrWe_o,
    output logic [addrWidth-1:0] clrAddr_o
);
    import dual_port_ssram_pkg::*;

    localparam logic [addrWidth-1:0] LAST = addrWidth'(nrOfEntries - 1);

    clr_state_e           state_q, state_d;
    logic [addrWidth-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= clearOnReset ? CLEAR : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = READY;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        busy_o    = (state_q == CLEAR);
        clrWe_o   = (state_q == CLEAR);
        clrAddr_o = cnt_q;
    end

endmodule

// File: rtl/dual_port_ssram_be.sv
// True dual-port single-clock SSRAM with byte enables, write-first/read-first
// selection, optional output register, A-priority collision merge and clear-on-reset.
module dual_port_ssram_be #(
    parameter int                 bitwidth       = 32,
    parameter int                 nrOfEntries    = 512,
    parameter int                 readAfterWrite = 0,
    parameter int                 outputRegister = 0,
    parameter int                 clearOnReset   = 1,
    parameter logic [bitwidth-1:0] clearValue    = '0,
    localparam int                AW             = (nrOfEntries > 1) ? $clog2(nrOfEntries) : 1,
    localparam int                NB             = bitwidth / 8
) (
    input  logic                clock,
    input  logic                reset,
    output logic                busy,
    input  logic                writeEnableA,
    input  logic                writeEnableB,
    input  logic                readEnableA,
    input  logic                readEnableB,
    input  logic [NB-1:0]       byteEnableA,
    input  logic [NB-1:0]       byteEnableB,
    input  logic [AW-1:0]       addressA,
    input  logic [AW-1:0]       addressB,
    input  logic [bitwidth-1:0] dataInA,
    input  logic [bitwidth-1:0] dataInB,
    output logic [bitwidth-1:0] dataOutA,
    output logic [bitwidth-1:0] dataOutB,
    output logic                collision
);
    import dual_port_ssram_pkg::*;

    localparam bit POW2 = ((1 << AW) == nrOfEntries);

    logic          clrWe;
    logic [AW-1:0] clrAddr;

    ssram_clear_sequencer #(
        .nrOfEntries (nrOfEntries),
        .clearOnReset(clearOnReset != 0),
        .addrWidth   (AW)
    ) u_clr (
        .clk_i    (clock),
        .rst_i    (reset),
        .busy_o   (busy),
        .clrWe_o  (clrWe),
        .clrAddr_o(clrAddr)
    );

    logic [bitwidth-1:0] mem_q [nrOfEntries];

    logic inRangeA, inRangeB;
    generate
        if (POW2) begin : g_pow2
            assign inRangeA = 1'b1;
            assign inRangeB = 1'b1;
        end else begin : g_npow2
            assign inRangeA = (32'(addressA) < nrOfEntries);
            assign inRangeB = (32'(addressB) < nrOfEntries);
        end
    endgenerate

    logic          accept;
    logic [NB-1:0] maskA, maskB;
    logic          wrA, wrB, sameAddr;

    // Effective byte masks already fold in busy, reset, strobe and range.
    assign accept   = !busy && !reset;
    assign maskA    = (accept && writeEnableA && inRangeA) ? byteEnableA : '0;
    assign maskB    = (accept && writeEnableB && inRangeB) ? byteEnableB : '0;
    assign wrA      = |maskA;
    assign wrB      = |maskB;
    assign sameAddr = (addressA == addressB);

    logic [bitwidth-1:0] oldA, oldB, newA_d, newB_d, rdA, rdB;
    wr_t                 both;

    always_comb begin
        oldA   = inRangeA ? mem_q[addressA] : '0;
        oldB   = inRangeB ? mem_q[addressB] : '0;
        both   = resolveWrite(word_t'(dataInA), mask_t'(maskA), word_t'(dataInB), mask_t'(maskB));
        newA_d = bitwidth'(mergeBytes(word_t'(oldA), word_t'(dataInA), mask_t'(maskA)));
        newB_d = bitwidth'(mergeBytes(word_t'(oldB), word_t'(dataInB), mask_t'(maskB)));
        if (wrA && wrB && sameAddr) begin
            newA_d = bitwidth'(mergeBytes(word_t'(oldA), both.data, both.mask));
            newB_d = newA_d;
        end
        rdA = oldA;
        rdB = oldB;
        if (readAfterWrite == 0) begin
            if (wrA)                 rdA = newA_d;
            else if (wrB && sameAddr) rdA = newB_d;
            if (wrB)                 rdB = newB_d;
            else if (wrA && sameAddr) rdB = newA_d;
        end
    end

    // A same-address double write commits once through port A with the resolved word.
    always_ff @(posedge clock) begin
        if (clrWe) begin
            mem_q[clrAddr] <= clearValue;
        end else begin
            if (wrA)                      mem_q[addressA] <= newA_d;
            if (wrB && !(wrA && sameAddr)) mem_q[addressB] <= newB_d;
        end
    end

    logic [bitwidth-1:0] s1A_q, s1B_q, s2A_q, s2B_q;
    logic                vldA_q, vldB_q, collision_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1A_q       <= '0;
            s1B_q       <= '0;
            s2A_q       <= '0;
            s2B_q       <= '0;
            vldA_q      <= 1'b0;
            vldB_q      <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            if (accept && readEnableA) s1A_q <= rdA;
            if (accept && readEnableB) s1B_q <= rdB;
            vldA_q <= accept && readEnableA;
            vldB_q <= accept && readEnableB;
            if (vldA_q) s2A_q <= s1A_q;
            if (vldB_q) s2B_q <= s1B_q;
            collision_q <= wrA && wrB && sameAddr && (|(maskA & maskB));
        end
    end

    assign dataOutA  = (outputRegister != 0) ? s2A_q : s1A_q;
    assign dataOutB  = (outputRegister != 0) ? s2B_q : s1B_q;
    assign collision = collision_q;

endmodule
